mem_interface: RTL and testbench
================================

Name: mem_interface

Overview:
- Memory-side stage between the CAP17 control unit and a synchronous single-port RAM.
- Accepts one-cycle read/write requests (address from a0, write data from the register-bank bus) and runs the RAM access with a programmable number of wait states.
- Returns read data and a one-cycle MemTrigger completion pulse that the control unit's fetch/load/store sequences wait on.
- Owns all RAM strobes; the control unit never drives the RAM directly.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- WAIT_CYCLES, 1, RAM wait states per access; legal range 0..15; sizes a 4-bit counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- rd_req  in  1  read request, sampled on posedge while idle.
- wr_req  in  1  write request (the control unit's MemWrite_enable), sampled on posedge while idle.
- addr  in  AW  access address, captured with the request.
- wdata  in  DW  write data, captured with the request.
- rdata  out  DW  last read data; held until the next completed read.
- mem_trigger  out  1  one-cycle completion pulse (MemTrigger).
- busy  out  1  high from request acceptance until completion.
- req_err  out  1  one-cycle pulse when rd_req and wr_req are sampled together.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address (registered).
- ram_wdata  out  DW  RAM write data (registered).
- ram_rdata  in  DW  RAM read data; valid while ram_ce is high after WAIT_CYCLES wait edges.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE and any in-flight access is aborted.
  - All outputs go to 0: rdata, mem_trigger, busy, req_err, ram_ce, ram_we, ram_addr, ram_wdata.
  - Wait counter goes to 0.
  - No mem_trigger is generated for an aborted access.
  - Released synchronously on the first posedge after reset goes high.
- FSM states: IDLE and ACCESS.
- IDLE, on posedge:
  - If rd_req or wr_req is high: capture addr and wdata into ram_addr/ram_wdata; set ram_ce=1; set ram_we=wr_req; set busy=1; load counter=WAIT_CYCLES; go to ACCESS.
  - Simultaneous rd_req and wr_req: the write wins and req_err pulses for one cycle.
- ACCESS, on posedge:
  - If counter is not 0: decrement it and hold every strobe, address and data value.
  - If counter is 0:
    - For a read, rdata <= ram_rdata.
    - Clear ram_ce, ram_we and busy.
    - Set mem_trigger=1 for exactly one cycle.
    - Return to IDLE.
- Latency: request sampled at edge T gives mem_trigger high in the cycle following edge T+WAIT_CYCLES+1. With WAIT_CYCLES=0, the request edge is followed by the trigger one edge later.
- Requests while busy are ignored and not queued; the control unit must hold off.
- A request present during the mem_trigger cycle is accepted, so back-to-back accesses have no dead cycle.
- ram_addr and ram_wdata keep their last values after completion; only ram_ce and ram_we return to 0.
- rdata is unchanged by writes.
- Address wrap-around is not applicable: the address is passed through unmodified at AW bits.

Optional Feature:
- Macro: MEM_LAST_READ_CACHE_EN.
- Defined: a one-entry cache holds the address and data of the last completed read, with a valid bit.
  - Hit: rd_req in IDLE with valid=1 and addr equal to the cached address. Completes on the next edge with rdata=cached data and mem_trigger pulsed. No ram_ce; busy stays 0.
  - A completed write to the cached address updates the cached data (write-through).
  - Reset clears the valid bit.
- Not defined: every read goes to RAM, no cache state is present, and timing is as above.

Test Plan:
- Reset: hold reset low for 3 cycles mid-read with WAIT_CYCLES=3 -> all outputs 0, no mem_trigger after release, next read completes normally.
- Read: WAIT_CYCLES=1, rd_req at addr 0x0040 with RAM returning 0xBEEF -> ram_ce high for 2 cycles, ram_we=0, mem_trigger one cycle later, rdata=0xBEEF, busy low again.
- Write, then read back: wr_req at addr 0x0041 with wdata 0x1234 -> ram_we high with ram_ce for WAIT_CYCLES+1 cycles, ram_addr=0x0041, rdata unchanged; subsequent read of 0x0041 -> rdata=0x1234.
- Collision and busy: rd_req and wr_req together -> req_err pulse and a write is performed; extra rd_req pulses while busy -> ignored, exactly one mem_trigger.
- Back-to-back: WAIT_CYCLES=0, rd_req held high on three consecutive requests -> mem_trigger every 2 cycles, no lost requests.
- MEM_LAST_READ_CACHE_EN:
  - Re-read 0x0040 -> trigger after 1 edge with no ram_ce.
  - Write 0x5555 to 0x0040, then read -> cache hit returns 0x5555.

Source files
------------

// File: rtl/mem_interface_if.sv
// mem_interface_if: bundles the control-unit request/response signals and the RAM-side
// strobes of the memory stage.
//   slave  : seen by mem_interface (samples requests and ram_rdata, drives everything else).
//   master : seen by the environment (control unit plus RAM).
// Parameters: AW address width, DW data width.
interface mem_interface_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    // Control-unit side
    logic          rd_req;
    logic          wr_req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          mem_trigger;
    logic          busy;
    logic          req_err;
    // RAM side
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  rd_req, wr_req, addr, wdata, ram_rdata,
        output rdata, mem_trigger, busy, req_err, ram_ce, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output rd_req, wr_req, addr, wdata, ram_rdata,
        input  rdata, mem_trigger, busy, req_err, ram_ce, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_interface.sv
// mem_interface: memory-side stage between the CAP17 control unit and a synchronous
// single-port RAM. Accepts one-cycle read/write requests, runs the RAM access with
// WAIT_CYCLES wait states and signals completion with a one-cycle mem_trigger pulse.
// Ports:
//   clk    system clock, all state changes on posedge
//   reset  asynchronous active-low reset
//   bus    mem_interface_if.slave: rd_req/wr_req/addr/wdata in, rdata/mem_trigger/busy/
//          req_err out; ram_ce/ram_we/ram_addr/ram_wdata out, ram_rdata in
// Parameters: AW, DW widths; WAIT_CYCLES wait states per access (0..15).
// Optional feature: define MEM_LAST_READ_CACHE_EN for a one-entry last-read cache
// (write-through); reads hitting it complete in one edge without touching the RAM.
module mem_interface #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int WAIT_CYCLES = 1
) (
    input logic            clk,
    input logic            reset,
    mem_interface_if.slave bus
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    typedef enum logic {
        StIdle,
        StAccess
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          trig_q, trig_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          ce_q, ce_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          any_req;
    logic          complete;
    logic          cache_hit;
    logic [DW-1:0] cache_data;

    assign any_req  = bus.rd_req | bus.wr_req;
    assign complete = (state_q == StAccess) && (cnt_q == 4'd0);

`ifdef MEM_LAST_READ_CACHE_EN
    logic          cvalid_q;
    logic [AW-1:0] caddr_q;
    logic [DW-1:0] cdata_q;

    // A collision counts as a write, so only a pure read may hit.
    assign cache_hit  = (state_q == StIdle) && bus.rd_req && !bus.wr_req && cvalid_q &&
                        (bus.addr == caddr_q);
    assign cache_data = cdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cvalid_q <= 1'b0;
            caddr_q  <= '0;
            cdata_q  <= '0;
        end else if (complete) begin
            if (!we_q) begin
                cvalid_q <= 1'b1;
                caddr_q  <= addr_q;
                cdata_q  <= bus.ram_rdata;
            end else if (cvalid_q && (addr_q == caddr_q)) begin
                cdata_q <= wdata_q;
            end
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        trig_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;
        ce_d    = ce_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (cache_hit) begin
                    rdata_d = cache_data;
                    trig_d  = 1'b1;
                end else if (any_req) begin
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    ce_d    = 1'b1;
                    we_d    = bus.wr_req;   // write wins a collision
                    busy_d  = 1'b1;
                    cnt_d   = WaitLoad;
                    err_d   = bus.rd_req & bus.wr_req;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        rdata_d = bus.ram_rdata;
                    end
                    ce_d    = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    trig_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ce_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.mem_trigger = trig_q;
    assign bus.busy        = busy_q;
    assign bus.req_err     = err_q;
    assign bus.ram_ce      = ce_q;
    assign bus.ram_we      = we_q;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: drives three mem_interface instances (WAIT_CYCLES 3, 1, 0) with the same
// directed request stream. Each has its own behavioural RAM. A transaction-level model
// predicts every output; a negedge process compares all outputs every cycle, and the
// stimulus adds hand-computed literal expectations.
module tb_mem_interface;

    localparam int N = 3;

`ifdef MEM_LAST_READ_CACHE_EN
    localparam bit CacheOn = 1'b1;
`else
    localparam bit CacheOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wire [15:0] act_rdata [N];
    wire [15:0] act_raddr [N];
    wire [15:0] act_rwdata [N];
    wire        act_trig [N];
    wire        act_busy [N];
    wire        act_err [N];
    wire        act_ce [N];
    wire        act_we [N];

    function automatic int wait_of(input int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : 0;
    endfunction

    function automatic logic [15:0] init_val(input int a);
        if (a == 'h40) return 16'hBEEF;
        return 16'hC000 | 16'(a);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int W = (g == 0) ? 3 : (g == 1) ? 1 : 0;
        logic [15:0] ram [256];

        mem_interface_if #(.AW(16), .DW(16)) bus ();

        mem_interface #(.AW(16), .DW(16), .WAIT_CYCLES(W)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.rd_req    = rd_req;
        assign bus.wr_req    = wr_req;
        assign bus.addr      = addr;
        assign bus.wdata     = wdata;
        assign bus.ram_rdata = ram[bus.ram_addr[7:0]];

        initial begin
            for (int a = 0; a < 256; a++) ram[a] = init_val(a);
            forever begin
                @(posedge clk);
                if (bus.ram_ce && bus.ram_we) ram[bus.ram_addr[7:0]] <= bus.ram_wdata;
            end
        end

        assign act_rdata[g]  = bus.rdata;
        assign act_raddr[g]  = bus.ram_addr;
        assign act_rwdata[g] = bus.ram_wdata;
        assign act_trig[g]   = bus.mem_trigger;
        assign act_busy[g]   = bus.busy;
        assign act_err[g]    = bus.req_err;
        assign act_ce[g]     = bus.ram_ce;
        assign act_we[g]     = bus.ram_we;
    end

    // ---------------- transaction-level model ----------------
    bit          inflt [N];
    bit          is_wr [N];
    logic [15:0] acc_a [N];
    logic [15:0] acc_d [N];
    int          done_at [N];
    logic [15:0] mmem [N][256];
    bit          cvalid [N];
    logic [15:0] cad [N];
    logic [15:0] cdat [N];
    int          ncyc;

    logic [15:0] exp_rdata [N];
    bit          exp_trig [N];
    bit          exp_err [N];

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            inflt[i]     = 1'b0;
            is_wr[i]     = 1'b0;
            acc_a[i]     = '0;
            acc_d[i]     = '0;
            cvalid[i]    = 1'b0;
            exp_rdata[i] = '0;
            exp_trig[i]  = 1'b0;
            exp_err[i]   = 1'b0;
        end
    endtask

    initial begin
        ncyc = 0;
        for (int i = 0; i < N; i++)
            for (int a = 0; a < 256; a++) mmem[i][a] = init_val(a);
        clear_model();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                clear_model();
            end else begin
                ncyc++;
                for (int i = 0; i < N; i++) begin
                    exp_trig[i] = 1'b0;
                    exp_err[i]  = 1'b0;
                    if (!inflt[i]) begin
                        if (CacheOn && rd_req && !wr_req && cvalid[i] && cad[i] == addr) begin
                            exp_trig[i]  = 1'b1;
                            exp_rdata[i] = cdat[i];
                        end else if (rd_req || wr_req) begin
                            inflt[i]   = 1'b1;
                            is_wr[i]   = wr_req;
                            acc_a[i]   = addr;
                            acc_d[i]   = wdata;
                            done_at[i] = ncyc + wait_of(i) + 1;
                            exp_err[i] = rd_req && wr_req;
                        end
                    end else if (ncyc == done_at[i]) begin
                        inflt[i]    = 1'b0;
                        exp_trig[i] = 1'b1;
                        if (is_wr[i]) begin
                            mmem[i][acc_a[i][7:0]] = acc_d[i];
                            if (cvalid[i] && cad[i] == acc_a[i]) cdat[i] = acc_d[i];
                        end else begin
                            exp_rdata[i] = mmem[i][acc_a[i][7:0]];
                            cvalid[i]    = 1'b1;
                            cad[i]       = acc_a[i];
                            cdat[i]      = exp_rdata[i];
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %h expected %h", name, inst, $time, act, exp);
        end
    endtask

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                chk("rdata", i, act_rdata[i], exp_rdata[i]);
                chk("mem_trigger", i, 16'(act_trig[i]), 16'(exp_trig[i]));
                chk("busy", i, 16'(act_busy[i]), 16'(inflt[i]));
                chk("req_err", i, 16'(act_err[i]), 16'(exp_err[i]));
                chk("ram_ce", i, 16'(act_ce[i]), 16'(inflt[i]));
                chk("ram_we", i, 16'(act_we[i]), 16'(inflt[i] && is_wr[i]));
                chk("ram_addr", i, act_raddr[i], acc_a[i]);
                chk("ram_wdata", i, act_rwdata[i], acc_d[i]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d);
        rd_req = rd;
        wr_req = wr;
        addr   = a;
        wdata  = d;
        tick(1);
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    int n0, n1, n2;

    initial begin
        // Reset state
        tick(3);
        chk("lit_reset_busy", 0, 16'(act_busy[0]), 16'd0);
        chk("lit_reset_ce", 0, 16'(act_ce[0]), 16'd0);
        chk("lit_reset_rdata", 0, act_rdata[0], 16'h0000);
        chk("lit_reset_addr", 0, act_raddr[0], 16'h0000);
        reset = 1'b1;
        tick(1);

        // Reset in the middle of a read on the 3-wait-state instance
        req(1'b1, 1'b0, 16'h0010, 16'h0000);
        tick(1);
        chk("lit_midread_busy", 0, 16'(act_busy[0]), 16'd1);
        reset = 1'b0;
        tick(3);
        chk("lit_abort_busy", 0, 16'(act_busy[0]), 16'd0);
        chk("lit_abort_ce", 0, 16'(act_ce[0]), 16'd0);
        reset = 1'b1;
        tick(8);
        req(1'b1, 1'b0, 16'h0010, 16'h0000);
        tick(8);
        chk("lit_after_reset_rdata", 0, act_rdata[0], 16'hC010);

        // Read with one wait state
        req(1'b1, 1'b0, 16'h0040, 16'h0000);
        chk("lit_read_ce", 1, 16'(act_ce[1]), 16'd1);
        tick(2);
        chk("lit_read_trig", 1, 16'(act_trig[1]), 16'd1);
        chk("lit_read_rdata", 1, act_rdata[1], 16'hBEEF);
        tick(1);
        chk("lit_read_busy_low", 1, 16'(act_busy[1]), 16'd0);
        tick(6);

        // Write, then read back
        req(1'b0, 1'b1, 16'h0041, 16'h1234);
        chk("lit_write_we", 1, 16'(act_we[1]), 16'd1);
        chk("lit_write_addr", 1, act_raddr[1], 16'h0041);
        tick(8);
        chk("lit_write_rdata_kept", 1, act_rdata[1], 16'hBEEF);
        req(1'b1, 1'b0, 16'h0041, 16'h0000);
        tick(8);
        chk("lit_readback", 1, act_rdata[1], 16'h1234);
        chk("lit_readback", 0, act_rdata[0], 16'h1234);

        // Collision, then reads while busy
        req(1'b1, 1'b1, 16'h0042, 16'hABCD);
        chk("lit_collision_err", 1, 16'(act_err[1]), 16'd1);
        chk("lit_collision_we", 1, 16'(act_we[1]), 16'd1);
        rd_req = 1'b1;
        addr   = 16'h0043;
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            if (k == 1) rd_req = 1'b0;
            n0 += int'(act_trig[0]);
            n1 += int'(act_trig[1]);
        end
        chk("lit_busy_one_trigger", 0, 16'(n0), 16'd1);
        chk("lit_busy_one_trigger", 1, 16'(n1), 16'd1);
        req(1'b1, 1'b0, 16'h0042, 16'h0000);
        tick(8);
        chk("lit_collision_wrote", 0, act_rdata[0], 16'hABCD);

        // Back-to-back reads held high, zero wait states
        rd_req = 1'b1;
        addr   = 16'h0050;
        n2 = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (k == 4) rd_req = 1'b0;
            n2 += int'(act_trig[2]);
        end
        chk("lit_b2b_triggers", 2, 16'(n2), 16'd3);
        tick(8);

        // Re-read and write-through behaviour
        req(1'b1, 1'b0, 16'h0040, 16'h0000);
        tick(8);
        req(1'b1, 1'b0, 16'h0040, 16'h0000);
        if (CacheOn) begin
            chk("lit_hit_trig", 0, 16'(act_trig[0]), 16'd1);
            chk("lit_hit_no_ce", 0, 16'(act_ce[0]), 16'd0);
            chk("lit_hit_rdata", 0, act_rdata[0], 16'hBEEF);
        end
        tick(8);
        req(1'b0, 1'b1, 16'h0040, 16'h5555);
        tick(8);
        req(1'b1, 1'b0, 16'h0040, 16'h0000);
        if (CacheOn) begin
            chk("lit_wt_hit_trig", 0, 16'(act_trig[0]), 16'd1);
            chk("lit_wt_hit_rdata", 0, act_rdata[0], 16'h5555);
        end
        tick(8);
        chk("lit_wt_rdata", 0, act_rdata[0], 16'h5555);
        chk("lit_wt_rdata", 2, act_rdata[2], 16'h5555);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
